// File: rtl/dice_pkg.sv
// Shared types and constants for the craps dice game controller.
package dice_pkg;

    localparam int SUM_W = 4;

    localparam logic [2:0]       DIE_MIN    = 3'd1;
    localparam logic [2:0]       DIE_MAX    = 3'd6;
    localparam logic [SUM_W-1:0] SUM_SEVEN  = 4'd7;
    localparam logic [SUM_W-1:0] SUM_ELEVEN = 4'd11;
    localparam logic [SUM_W-1:0] CRAPS_2    = 4'd2;
    localparam logic [SUM_W-1:0] CRAPS_3    = 4'd3;
    localparam logic [SUM_W-1:0] CRAPS_12   = 4'd12;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SAMPLE = 3'd1,
        EVAL   = 3'd2,
        POINT  = 3'd3,
        WIN    = 3'd4,
        LOSE   = 3'd5
    } state_t;

endpackage

// File: rtl/dice_game_ctrl_craps_rules.sv
// Combinational craps rule decision for one evaluated roll.
module craps_rules
    import dice_pkg::*;
(
    input  logic [SUM_W-1:0] sum,
    input  logic [SUM_W-1:0] point,
    input  logic             come_out,
    output logic             is_win,
    output logic             is_lose,
    output logic             set_point
);

    // Come-out uses natural/craps rules; later rolls race the point against seven.
    always_comb begin
        is_win    = 1'b0;
        is_lose   = 1'b0;
        set_point = 1'b0;
        if (come_out) begin
            if ((sum == SUM_SEVEN) || (sum == SUM_ELEVEN)) begin
                is_win = 1'b1;
            end else if ((sum == CRAPS_2) || (sum == CRAPS_3) || (sum == CRAPS_12)) begin
                is_lose = 1'b1;
            end else begin
                set_point = 1'b1;
            end
        end else begin
            if (sum == point) begin
                is_win = 1'b1;
            end else if (sum == SUM_SEVEN) begin
                is_lose = 1'b1;
            end else begin
                is_win = 1'b0;
            end
        end
    end

endmodule

// File: rtl/dice_game_ctrl.sv
// Craps game sequencer: roll edge detect, dice sampling, rule evaluation and
// registered status outputs for the display/LED drivers.
module dice_game_ctrl
    import dice_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             roll,
    input  logic [2:0]       dice1,
    input  logic [2:0]       dice2,
    output logic             sample_strobe,
    output logic [3:0]       sum,
    output logic [3:0]       point,
    output logic             point_valid,
    output logic             win,
    output logic             lose,
    output logic             result_valid,
    output logic             busy,
    output logic [CNT_W-1:0] roll_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r, state_s;
    logic             come_out_r, come_out_s;
    logic             roll_q_r;
    logic             armed_r;
    logic [3:0]       sum_r, sum_s;
    logic [3:0]       point_r, point_s;
    logic             point_valid_r, point_valid_s;
    logic             win_r, win_s;
    logic             lose_r, lose_s;
    logic             strobe_r, strobe_s;
    logic             result_valid_r, result_valid_s;
    logic             busy_r, busy_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;

    logic             roll_rise_s;
    logic             dice_ok_s;
    logic [3:0]       dice_sum_s;
    logic             is_win_s, is_lose_s, set_point_s;

    // armed_r masks the first post-reset cycle so a roll held through reset is not a press.
    assign roll_rise_s = roll & ~roll_q_r & armed_r;
    assign dice_ok_s   = (dice1 >= DIE_MIN) && (dice1 <= DIE_MAX) &&
                         (dice2 >= DIE_MIN) && (dice2 <= DIE_MAX);
    assign dice_sum_s  = {1'b0, dice1} + {1'b0, dice2};

    craps_rules u_rules (
        .sum       (sum_r),
        .point     (point_r),
        .come_out  (come_out_r),
        .is_win    (is_win_s),
        .is_lose   (is_lose_s),
        .set_point (set_point_s)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_s        = state_r;
        come_out_s     = come_out_r;
        sum_s          = sum_r;
        point_s        = point_r;
        point_valid_s  = point_valid_r;
        win_s          = win_r;
        lose_s         = lose_r;
        cnt_s          = cnt_r;
        strobe_s       = 1'b0;
        result_valid_s = 1'b0;
        case (state_r)
            IDLE, POINT: begin
                if (roll_rise_s) begin
                    state_s = SAMPLE;
                end else begin
                    state_s = state_r;
                end
            end
            SAMPLE: begin
                if (dice_ok_s) begin
                    sum_s    = dice_sum_s;
                    strobe_s = 1'b1;
                    state_s  = EVAL;
                    if (cnt_r != CNT_MAX) begin
                        cnt_s = cnt_r + CNT_ONE;
                    end else begin
                        cnt_s = cnt_r;
                    end
                end else begin
                    state_s = SAMPLE;
                end
            end
            EVAL: begin
                result_valid_s = 1'b1;
                if (is_win_s) begin
                    state_s       = WIN;
                    win_s         = 1'b1;
                    point_valid_s = 1'b0;
                end else if (is_lose_s) begin
                    state_s       = LOSE;
                    lose_s        = 1'b1;
                    point_valid_s = 1'b0;
                end else begin
                    state_s = POINT;
                    if (set_point_s) begin
                        point_s       = sum_r;
                        point_valid_s = 1'b1;
                        come_out_s    = 1'b0;
                    end else begin
                        point_s = point_r;
                    end
                end
            end
            WIN, LOSE: begin
                // A press here starts the next game and samples in the same step.
                if (roll_rise_s) begin
                    win_s      = 1'b0;
                    lose_s     = 1'b0;
                    point_s    = 4'd0;
                    cnt_s      = {CNT_W{1'b0}};
                    come_out_s = 1'b1;
                    state_s    = SAMPLE;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s == SAMPLE) || (state_s == EVAL);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            come_out_r     <= 1'b1;
            roll_q_r       <= 1'b0;
            armed_r        <= 1'b0;
            sum_r          <= 4'd0;
            point_r        <= 4'd0;
            point_valid_r  <= 1'b0;
            win_r          <= 1'b0;
            lose_r         <= 1'b0;
            strobe_r       <= 1'b0;
            result_valid_r <= 1'b0;
            busy_r         <= 1'b0;
            cnt_r          <= {CNT_W{1'b0}};
        end else begin
            state_r        <= state_s;
            come_out_r     <= come_out_s;
            roll_q_r       <= roll;
            armed_r        <= 1'b1;
            sum_r          <= sum_s;
            point_r        <= point_s;
            point_valid_r  <= point_valid_s;
            win_r          <= win_s;
            lose_r         <= lose_s;
            strobe_r       <= strobe_s;
            result_valid_r <= result_valid_s;
            busy_r         <= busy_s;
            cnt_r          <= cnt_s;
        end
    end

    assign sample_strobe = strobe_r;
    assign sum           = sum_r;
    assign point         = point_r;
    assign point_valid   = point_valid_r;
    assign win           = win_r;
    assign lose          = lose_r;
    assign result_valid  = result_valid_r;
    assign busy          = busy_r;
    assign roll_count    = cnt_r;

endmodule

// File: tb/tb_dice_game_ctrl.sv
// Self-checking bench for dice_game_ctrl: craps reference model feeding a
// result scoreboard, plus cycle-level latency, busy and reset checks.
module tb_dice_game_ctrl;

    typedef struct packed {
        logic [3:0] sum;
        logic       win;
        logic       lose;
        logic [3:0] point;
        logic       point_valid;
        logic [7:0] cnt;
    } res_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       roll = 1'b0;
    logic [2:0] dice1 = 3'd1;
    logic [2:0] dice2 = 3'd1;
    logic       sample_strobe, point_valid, win, lose, result_valid, busy;
    logic [3:0] sum, point;
    logic [7:0] roll_count;

    int checks = 0;
    int errors = 0;

    res_t exp_q[$];
    res_t got_a [0:1023];
    int   got_cnt = 0;
    int   rd_idx = 0;
    int   strobe_cnt = 0;

    int   m_cnt = 0;
    int   m_point = 0;
    bit   m_come_out = 1'b1;
    bit   m_over = 1'b0;

    dice_game_ctrl #(.CNT_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .roll          (roll),
        .dice1         (dice1),
        .dice2         (dice2),
        .sample_strobe (sample_strobe),
        .sum           (sum),
        .point         (point),
        .point_valid   (point_valid),
        .win           (win),
        .lose          (lose),
        .result_valid  (result_valid),
        .busy          (busy),
        .roll_count    (roll_count)
    );

    always #5 clk = ~clk;

    // Capture every evaluated roll and count sample strobes.
    always @(negedge clk) begin
        if (sample_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;
        if (result_valid === 1'b1 && got_cnt < 1024) begin
            got_a[got_cnt] <= {sum, win, lose, point, point_valid, roll_count};
            got_cnt        <= got_cnt + 1;
        end
    end

    task automatic model_reset;
        m_cnt = 0; m_point = 0; m_come_out = 1'b1; m_over = 1'b0;
    endtask

    task automatic model_roll(input int d1, input int d2);
        res_t e;
        int   s;
        bit   w, l;
        s = d1 + d2;
        w = 1'b0; l = 1'b0;
        if (m_over) begin
            m_cnt = 0; m_point = 0; m_come_out = 1'b1; m_over = 1'b0;
        end
        if (m_cnt < 255) m_cnt++;
        if (m_come_out) begin
            if (s == 7 || s == 11) w = 1'b1;
            else if (s == 2 || s == 3 || s == 12) l = 1'b1;
            else begin m_point = s; m_come_out = 1'b0; end
        end else begin
            if (s == m_point) w = 1'b1;
            else if (s == 7) l = 1'b1;
        end
        m_over = w | l;
        e.sum = 4'(s); e.win = w; e.lose = l; e.point = 4'(m_point);
        e.point_valid = !m_over && !m_come_out; e.cnt = 8'(m_cnt);
        exp_q.push_back(e);
    endtask

    task automatic press(input logic [2:0] d1, input logic [2:0] d2);
        model_roll(int'(d1), int'(d2));
        @(posedge clk); #2;
        dice1 = d1; dice2 = d2; roll = 1'b1;
        @(posedge clk); #2;
        roll = 1'b0;
    endtask

    task automatic sb_get(output res_t g, output res_t e, output bit ok);
        ok = 1'b0; g = '0; e = '0;
        for (int i = 0; i < 40 && got_cnt <= rd_idx; i++) @(posedge clk);
        #1;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        if (got_cnt > rd_idx) begin
            g = got_a[rd_idx];
            rd_idx++;
            ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; roll = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({sample_strobe, sum, point, point_valid, win, lose, result_valid, busy, roll_count} !== 23'd0) begin
            errors++;
            $display("FAIL reset_values: got %h, expected 0",
                     {sample_strobe, sum, point, point_valid, win, lose, result_valid, busy, roll_count});
        end
        #1 rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
    endtask

    task automatic test_come_out_win;
        res_t g, e; bit ok;
        model_roll(3, 4);
        @(posedge clk); #2;
        dice1 = 3'd3; dice2 = 3'd4; roll = 1'b1;
        @(posedge clk); #2;
        roll = 1'b0;
        checks++;
        if (busy !== 1'b1 || sample_strobe !== 1'b0) begin
            errors++; $display("FAIL latency_sample: busy=%b strobe=%b, expected 1 0", busy, sample_strobe);
        end
        @(posedge clk); #1;
        checks++;
        if (sample_strobe !== 1'b1 || sum !== 4'd7 || result_valid !== 1'b0) begin
            errors++; $display("FAIL latency_strobe: strobe=%b sum=%0d rv=%b, expected 1 7 0", sample_strobe, sum, result_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (result_valid !== 1'b1 || win !== 1'b1 || lose !== 1'b0 || point_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL latency_result: rv=%b win=%b lose=%b pv=%b busy=%b, expected 1 1 0 0 0",
                               result_valid, win, lose, point_valid, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (result_valid !== 1'b0 || win !== 1'b1) begin
            errors++; $display("FAIL result_pulse: rv=%b win=%b, expected 0 1", result_valid, win);
        end
        sb_get(g, e, ok);
        checks++;
        if (!ok || g !== e) begin
            errors++; $display("FAIL come_out_win: got %h expected %h (sum,win,lose,point,pv,cnt) ok=%b", g, e, ok);
        end
    endtask

    task automatic test_craps;
        res_t g, e; bit ok;
        press(3'd1, 3'd1);
        sb_get(g, e, ok);
        checks++;
        if (!ok || g !== e) begin
            errors++; $display("FAIL craps_2: got %h expected %h ok=%b", g, e, ok);
        end
        press(3'd6, 3'd6);
        sb_get(g, e, ok);
        checks++;
        if (!ok || g !== e || roll_count !== 8'd1) begin
            errors++; $display("FAIL craps_12_new_game: got %h expected %h cnt=%0d ok=%b", g, e, roll_count, ok);
        end
    endtask

    task automatic test_point_made;
        res_t g, e; bit ok;
        logic [2:0] d1 [3];
        logic [2:0] d2 [3];
        d1 = '{3'd2, 3'd1, 3'd5};
        d2 = '{3'd4, 3'd2, 3'd1};
        for (int i = 0; i < 3; i++) begin
            press(d1[i], d2[i]);
            sb_get(g, e, ok);
            checks++;
            if (!ok || g !== e) begin
                errors++; $display("FAIL point_made_%0d: got %h expected %h ok=%b", i, g, e, ok);
            end
        end
        checks++;
        if (point !== 4'd6 || win !== 1'b1 || point_valid !== 1'b0) begin
            errors++; $display("FAIL point_hold: point=%0d win=%b pv=%b, expected 6 1 0", point, win, point_valid);
        end
    endtask

    task automatic test_seven_out;
        res_t g, e; bit ok;
        press(3'd4, 3'd4);
        sb_get(g, e, ok);
        checks++;
        if (!ok || g !== e || point !== 4'd8 || point_valid !== 1'b1) begin
            errors++; $display("FAIL point_8: got %h expected %h ok=%b", g, e, ok);
        end
        press(3'd3, 3'd4);
        sb_get(g, e, ok);
        checks++;
        if (!ok || g !== e || lose !== 1'b1 || win !== 1'b0) begin
            errors++; $display("FAIL seven_out: got %h expected %h ok=%b", g, e, ok);
        end
    endtask

    task automatic test_invalid_dice;
        res_t g, e; bit ok;
        model_roll(2, 5);
        @(posedge clk); #2;
        dice1 = 3'd0; dice2 = 3'd5; roll = 1'b1;
        @(posedge clk); #2;
        roll = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) dice1 = 3'd7;
            @(posedge clk); #1;
            checks++;
            if (busy !== 1'b1 || sample_strobe !== 1'b0) begin
                errors++; $display("FAIL invalid_wait_%0d: busy=%b strobe=%b, expected 1 0", i, busy, sample_strobe);
            end
        end
        dice1 = 3'd2;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1 || sample_strobe !== 1'b1 || sum !== 4'd7) begin
            errors++; $display("FAIL invalid_accept: busy=%b strobe=%b sum=%0d, expected 1 1 7", busy, sample_strobe, sum);
        end
        sb_get(g, e, ok);
        checks++;
        if (!ok || g !== e) begin
            errors++; $display("FAIL invalid_result: got %h expected %h ok=%b", g, e, ok);
        end
    endtask

    task automatic test_held_roll;
        res_t g, e; bit ok;
        int s0;
        s0 = strobe_cnt;
        model_roll(5, 6);
        @(posedge clk); #2;
        dice1 = 3'd5; dice2 = 3'd6; roll = 1'b1;
        repeat (20) @(posedge clk);
        #2 roll = 1'b0;
        sb_get(g, e, ok);
        checks++;
        if (!ok || g !== e) begin
            errors++; $display("FAIL held_result: got %h expected %h ok=%b", g, e, ok);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (strobe_cnt - s0 != 1 || got_cnt != rd_idx) begin
            errors++; $display("FAIL held_single: strobes=%0d extra_results=%0d, expected 1 0", strobe_cnt - s0, got_cnt - rd_idx);
        end
    endtask

    task automatic test_reset_in_point;
        res_t g, e; bit ok;
        int s0;
        press(3'd4, 3'd4);
        sb_get(g, e, ok);
        checks++;
        if (!ok || g !== e || point_valid !== 1'b1) begin
            errors++; $display("FAIL pre_reset_point: got %h expected %h ok=%b", g, e, ok);
        end
        s0 = strobe_cnt;
        @(posedge clk); #2;
        roll = 1'b1; rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        model_reset();
        checks++;
        if (point !== 4'd0 || point_valid !== 1'b0 || roll_count !== 8'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_in_point: point=%0d pv=%b cnt=%0d busy=%b, expected 0 0 0 0",
                               point, point_valid, roll_count, busy);
        end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || strobe_cnt != s0) begin
            errors++; $display("FAIL held_through_reset: busy=%b strobes=%0d, expected 0 0", busy, strobe_cnt - s0);
        end
        roll = 1'b0;
        press(3'd5, 3'd2);
        sb_get(g, e, ok);
        checks++;
        if (!ok || g !== e) begin
            errors++; $display("FAIL after_reset_roll: got %h expected %h ok=%b", g, e, ok);
        end
    endtask

    task automatic test_saturation;
        res_t g, e; bit ok;
        press(3'd2, 3'd2);
        sb_get(g, e, ok);
        checks++;
        if (!ok || g !== e) begin
            errors++; $display("FAIL sat_point: got %h expected %h ok=%b", g, e, ok);
        end
        for (int i = 0; i < 258; i++) begin
            press(3'd3, 3'd3);
            sb_get(g, e, ok);
            checks++;
            if (!ok || g !== e) begin
                errors++; $display("FAIL sat_roll_%0d: got %h expected %h ok=%b", i, g, e, ok);
            end
        end
        checks++;
        if (roll_count !== 8'hFF || point_valid !== 1'b1) begin
            errors++; $display("FAIL sat_final: cnt=%0d pv=%b, expected 255 1", roll_count, point_valid);
        end
    endtask

    initial begin
        test_reset();
        test_come_out_win();
        test_craps();
        test_point_made();
        test_seven_out();
        test_invalid_dice();
        test_held_roll();
        test_reset_in_point();
        test_saturation();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (got_cnt != rd_idx || exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: unread=%0d pending=%0d, expected 0 0", got_cnt - rd_idx, exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
